// File: rtl/out_width_converter_pkg.sv
// Shared definitions for the wide-to-narrow output width converter:
// FSM state encoding and default beat geometry.
package out_width_converter_pkg;

    localparam int DEF_IN_WIDTH  = 256;
    localparam int DEF_OUT_WIDTH = 64;
    localparam int DEF_LEN_WIDTH = 17;
    localparam int DEF_RATIO     = DEF_IN_WIDTH / DEF_OUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/out_width_converter.sv
// Splits each IN_WIDTH beat of a fixed-length frame into RATIO OUT_WIDTH beats,
// lowest lane first, with a no-bubble reload on the final lane.
module out_width_converter
    import out_width_converter_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [LEN_WIDTH-1:0] Frame_Len,
    input  logic [IN_WIDTH-1:0]  S_Data,
    input  logic                 S_Valid,
    output logic                 S_Ready,
    output logic [OUT_WIDTH-1:0] M_Data,
    output logic                 M_Valid,
    input  logic                 M_Ready,
    output logic                 M_Last,
    output logic                 Busy,
    output logic                 Done
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    state_t               state;
    logic [LEN_WIDTH-1:0] frame_len;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LANE_W-1:0]    lane;
    logic [IN_WIDTH-1:0]  holding;

    logic last_lane;
    logic last_beat;
    logic m_fire;
    logic s_fire;

    // frame_len is never 0 while in SEND, so the subtraction cannot underflow there
    assign last_lane = (lane == LAST_LANE);
    assign last_beat = (beat_cnt == frame_len - 1'b1);

    assign M_Valid = (state == SEND);
    assign M_Last  = M_Valid && last_lane && last_beat;
    assign S_Ready = (state == LOAD) || (M_Valid && last_lane && M_Ready && !last_beat);
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);

    assign m_fire = M_Valid && M_Ready;
    assign s_fire = S_Valid && S_Ready;

    always_comb begin
        M_Data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) begin
                M_Data = holding[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            frame_len <= '0;
            beat_cnt  <= '0;
            lane      <= '0;
            holding   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        frame_len <= Frame_Len;
                        beat_cnt  <= '0;
                        lane      <= '0;
                        state     <= (Frame_Len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (s_fire) begin
                        holding <= S_Data;
                        lane    <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (m_fire) begin
                        if (!last_lane) begin
                            lane <= lane + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (last_beat) begin
                                state <= DONE;
                            end else if (s_fire) begin
                                // next wide beat arrives on the same edge: keep streaming
                                holding <= S_Data;
                                lane    <= '0;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_width_converter.sv
// Scoreboard bench for out_width_converter: source pushes expected narrow beats
// on each accepted wide beat, sink pops and compares on every output transfer.
module tb_out_width_converter;

    localparam int IW = 256;
    localparam int OW = 64;
    localparam int LW = 17;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Start = 1'b0;
    logic [LW-1:0] Frame_Len = '0;
    logic [IW-1:0] S_Data = '0;
    logic          S_Valid = 1'b0;
    logic          S_Ready;
    logic [OW-1:0] M_Data;
    logic          M_Valid;
    logic          M_Ready = 1'b1;
    logic          M_Last;
    logic          Busy;
    logic          Done;

    out_width_converter #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .LEN_WIDTH(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .Frame_Len(Frame_Len),
        .S_Data   (S_Data),
        .S_Valid  (S_Valid),
        .S_Ready  (S_Ready),
        .M_Data   (M_Data),
        .M_Valid  (M_Valid),
        .M_Ready  (M_Ready),
        .M_Last   (M_Last),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit abort = 1'b0;
    logic [OW:0] exp_q[$];

    int st_xfer, st_last, st_last_at, st_last_cyc, st_valid, st_first, st_lastv;
    int st_done, st_done_cyc, st_busy, st_sready;
    logic [LW-1:0] st_done_beat;

    function automatic logic [IW-1:0] mk_beat(input int b, input int salt);
        logic [IW-1:0] r;
        r = '0;
        for (int l = 0; l < R; l++) r[l*OW +: OW] = {32'(salt + b), 32'(b*R + l + 1)};
        return r;
    endfunction

    task automatic start_frame(input int len);
        @(posedge clk); #1;
        Start = 1'b1;
        Frame_Len = LW'(len);
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic source(input int len, input int gap, input int salt);
        int t;
        bit acc;
        logic [IW-1:0] d;
        for (int b = 0; b < len; b++) begin
            if (abort) break;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            d = mk_beat(b, salt);
            S_Valid = 1'b1;
            S_Data = d;
            t = 0;
            acc = 1'b0;
            while (!acc && !abort && t < 500) begin
                @(negedge clk);
                t++;
                if (!abort && S_Ready) acc = 1'b1;
            end
            if (!acc) begin
                if (!abort) begin
                    tests++; fails++;
                    $display("FAIL source_accept beat %0d: S_Ready got 0, required 1", b);
                end
                break;
            end
            for (int l = 0; l < R; l++)
                exp_q.push_back({(b == len-1) && (l == R-1), d[l*OW +: OW]});
            @(posedge clk); #1;
            if (gap > 0 || b == len-1) S_Valid = 1'b0;
        end
        S_Valid = 1'b0;
    endtask

    task automatic sink(input int mode, input int max_cyc);
        int cyc, post;
        bit prev_stall, prev_acc;
        logic [OW-1:0] prev_d;
        logic prev_l;
        logic [OW:0] ex;
        cyc = 0; post = -1; prev_stall = 1'b0; prev_acc = 1'b0; prev_d = '0; prev_l = 1'b0;
        st_xfer = 0; st_last = 0; st_last_at = 0; st_last_cyc = 0; st_valid = 0; st_first = -1;
        st_lastv = 0; st_done = 0; st_done_cyc = 0; st_busy = 0; st_sready = 0; st_done_beat = '0;
        while (cyc < max_cyc && !abort) begin
            @(negedge clk);
            if (abort) break;
            cyc++;
            if (Busy) st_busy++;
            if (S_Ready) st_sready++;
            if (M_Valid) begin
                st_valid++;
                if (st_first < 0) st_first = cyc;
                st_lastv = cyc;
            end
            if (prev_acc) begin
                tests++;
                if (M_Valid !== 1'b1) begin
                    fails++;
                    $display("FAIL load_latency: M_Valid=%b, required 1", M_Valid);
                end
            end
            if (prev_stall) begin
                tests++;
                if (M_Valid !== 1'b1 || M_Data !== prev_d || M_Last !== prev_l) begin
                    fails++;
                    $display("FAIL stall_hold: got V=%b D=%h L=%b, required V=1 D=%h L=%b",
                             M_Valid, M_Data, M_Last, prev_d, prev_l);
                end
            end
            if (M_Valid && M_Ready) begin
                tests++;
                st_xfer++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got D=%h L=%b, required no transfer", M_Data, M_Last);
                end else begin
                    ex = exp_q.pop_front();
                    if ({M_Last, M_Data} !== ex) begin
                        fails++;
                        $display("FAIL beat_%0d: got L=%b D=%h, required L=%b D=%h",
                                 st_xfer, M_Last, M_Data, ex[OW], ex[OW-1:0]);
                    end
                end
                if (M_Last) begin
                    st_last++;
                    st_last_at = st_xfer;
                    st_last_cyc = cyc;
                end
            end
            if (Done) begin
                st_done++;
                st_done_cyc = cyc;
                st_done_beat = dut.beat_cnt;
                if (post < 0) post = 2;
            end
            prev_stall = M_Valid && !M_Ready;
            prev_acc = S_Valid && S_Ready;
            prev_d = M_Data;
            prev_l = M_Last;
            if (post > 0) post--;
            if (post == 0) break;
            @(posedge clk); #1;
            M_Ready = (mode == 1) ? ~M_Ready : 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (S_Ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b, required 0", S_Ready); end
        tests++; if (M_Valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b, required 0", M_Valid); end
        tests++; if (M_Last !== 1'b0) begin fails++; $display("FAIL rst_m_last: got %b, required 0", M_Last); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", Busy); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, required 0", Done); end
        tests++; if (M_Data !== '0) begin fails++; $display("FAIL rst_m_data: got %h, required 0", M_Data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b, required 0", Busy); end
    endtask

    task automatic test_basic();
        exp_q.delete(); M_Ready = 1'b1;
        start_frame(2);
        fork
            source(2, 0, 0);
            sink(0, 200);
        join
        tests++; if (st_xfer != 8) begin fails++; $display("FAIL basic_xfers: got %0d, required 8", st_xfer); end
        tests++; if (st_last != 1 || st_last_at != 8) begin fails++; $display("FAIL basic_last: got count %0d at %0d, required 1 at 8", st_last, st_last_at); end
        tests++; if (st_valid != 8 || st_lastv - st_first + 1 != 8) begin fails++; $display("FAIL basic_contig: got %0d valid over %0d cycles, required 8 over 8", st_valid, st_lastv - st_first + 1); end
        tests++; if (st_done != 1 || st_done_cyc != st_last_cyc + 1) begin fails++; $display("FAIL basic_done: got %0d pulses at +%0d, required 1 at +1", st_done, st_done_cyc - st_last_cyc); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_zero_len();
        exp_q.delete(); M_Ready = 1'b1;
        start_frame(0);
        sink(0, 50);
        tests++; if (st_busy != 1) begin fails++; $display("FAIL zero_busy: got %0d cycles, required 1", st_busy); end
        tests++; if (st_done != 1) begin fails++; $display("FAIL zero_done: got %0d, required 1", st_done); end
        tests++; if (st_sready != 0) begin fails++; $display("FAIL zero_s_ready: got %0d, required 0", st_sready); end
        tests++; if (st_valid != 0) begin fails++; $display("FAIL zero_m_valid: got %0d, required 0", st_valid); end
    endtask

    task automatic test_backpressure();
        exp_q.delete(); M_Ready = 1'b1;
        start_frame(3);
        fork
            source(3, 0, 7);
            sink(1, 400);
        join
        M_Ready = 1'b1;
        tests++; if (st_xfer != 12) begin fails++; $display("FAIL bp_xfers: got %0d, required 12", st_xfer); end
        tests++; if (st_last != 1 || st_last_at != 12) begin fails++; $display("FAIL bp_last: got count %0d at %0d, required 1 at 12", st_last, st_last_at); end
        tests++; if (st_done != 1) begin fails++; $display("FAIL bp_done: got %0d, required 1", st_done); end
    endtask

    task automatic test_gaps();
        exp_q.delete(); M_Ready = 1'b1;
        start_frame(4);
        fork
            source(4, 5, 3);
            sink(0, 400);
        join
        tests++; if (st_xfer != 16 || st_valid != 16) begin fails++; $display("FAIL gap_xfers: got %0d xfers %0d valid, required 16 and 16", st_xfer, st_valid); end
        tests++; if (st_lastv - st_first + 1 <= 16) begin fails++; $display("FAIL gap_holes: got span %0d, required above 16", st_lastv - st_first + 1); end
        tests++; if (st_last != 1 || st_last_at != 16) begin fails++; $display("FAIL gap_last: got count %0d at %0d, required 1 at 16", st_last, st_last_at); end
        tests++; if (st_done != 1 || st_done_beat != LW'(4)) begin fails++; $display("FAIL gap_done: got %0d pulses beat_cnt %0d, required 1 and 4", st_done, st_done_beat); end
    endtask

    task automatic test_reset_midframe();
        int idle_act;
        exp_q.delete(); M_Ready = 1'b1; abort = 1'b0;
        start_frame(2);
        fork
            source(2, 0, 9);
            sink(0, 300);
            begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 100 && !hit; i++) begin
                    @(posedge clk); #2;
                    if (M_Valid && M_Data === {32'd10, 32'd7}) hit = 1'b1;
                end
                tests++;
                if (!hit) begin fails++; $display("FAIL rst_mid_reach: got no beat1 lane2, required it presented"); end
                abort = 1'b1;
                rst = 1'b0;
                #1;
                tests++;
                if ({S_Ready, M_Valid, M_Last, Busy, Done} !== 5'b0) begin
                    fails++;
                    $display("FAIL rst_mid_outputs: got SR=%b MV=%b ML=%b B=%b D=%b, required all 0",
                             S_Ready, M_Valid, M_Last, Busy, Done);
                end
            end
        join
        S_Valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        abort = 1'b0;
        idle_act = 0;
        repeat (5) begin
            @(negedge clk);
            if (M_Valid || Busy) idle_act++;
        end
        tests++; if (idle_act != 0) begin fails++; $display("FAIL rst_mid_idle: got %0d active cycles, required 0", idle_act); end
        start_frame(1);
        fork
            source(1, 0, 11);
            sink(0, 100);
        join
        tests++; if (st_xfer != 4 || st_last_at != 4) begin fails++; $display("FAIL rst_mid_after: got %0d xfers last at %0d, required 4 and 4", st_xfer, st_last_at); end
        tests++; if (st_done != 1) begin fails++; $display("FAIL rst_mid_done: got %0d, required 1", st_done); end
    endtask

    task automatic test_start_ignored();
        exp_q.delete(); M_Ready = 1'b1;
        start_frame(2);
        fork
            source(2, 0, 5);
            sink(0, 300);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (M_Valid) seen = 1'b1;
                end
                @(posedge clk); #1;
                Start = 1'b1;
                Frame_Len = LW'(7);
                @(posedge clk); #1;
                Start = 1'b0;
            end
        join
        tests++; if (st_xfer != 8) begin fails++; $display("FAIL start_ign_xfers: got %0d, required 8", st_xfer); end
        tests++; if (st_last != 1 || st_last_at != 8) begin fails++; $display("FAIL start_ign_last: got count %0d at %0d, required 1 at 8", st_last, st_last_at); end
        tests++; if (st_done != 1) begin fails++; $display("FAIL start_ign_done: got %0d, required 1", st_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_gaps();
        test_reset_midframe();
        test_start_ignored();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/out_width_converter.md
OUT_WIDTH_CONVERTER -- requirements
Module: out_width_converter

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 256, input beat width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 64, output beat width; IN_WIDTH/OUT_WIDTH SHALL be an integer power of two (RATIO, default 4).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 17, width of the frame beat count.
REQ-004 The block SHALL use a single clock, clk (input, 1), and all state SHALL be on its rising edge.
REQ-005 The block SHALL use reset rst (input, 1), asynchronous and active-low.
REQ-006 The block SHALL have Start (input, 1), a one-cycle request to begin a frame.
REQ-007 The block SHALL have Frame_Len (input, LEN_WIDTH), the number of IN_WIDTH beats in the frame, sampled on Start.
REQ-008 The block SHALL have S_Data (input, IN_WIDTH), S_Valid (input, 1) and S_Ready (output, 1), the upstream stream from the output buffer.
REQ-009 The block SHALL have M_Data (output, OUT_WIDTH), M_Valid (output, 1), M_Ready (input, 1) and M_Last (output, 1), the downstream stream to DMA.
REQ-010 The block SHALL have Busy (output, 1), high whenever the state is not IDLE.
REQ-011 The block SHALL have Done (output, 1), a one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SEND and DONE.
REQ-013 In IDLE with Start=1, the block SHALL latch Frame_Len, clear beat_cnt and lane, and go to LOAD; if Frame_Len=0 it SHALL go directly to DONE.
REQ-014 Start SHALL be ignored outside IDLE.
REQ-015 In LOAD, S_Ready SHALL be 1; on S_Valid&&S_Ready the block SHALL capture S_Data into a holding register, set lane=0, and go to SEND.
REQ-016 In SEND, M_Valid SHALL be 1 and M_Data SHALL be holding[(lane+1)*OUT_WIDTH-1 : lane*OUT_WIDTH], lowest lane first.
REQ-017 M_Data, M_Valid and M_Last SHALL remain stable while M_Valid=1 and M_Ready=0.
REQ-018 On M_Valid&&M_Ready with lane<RATIO-1, lane SHALL increment.
REQ-019 On M_Valid&&M_Ready with lane=RATIO-1, beat_cnt SHALL increment; the next state SHALL be DONE if beat_cnt+1=Frame_Len, otherwise LOAD.
REQ-020 No-bubble path: in SEND with lane=RATIO-1, M_Ready=1 and not the last beat, S_Ready SHALL be 1; an accepted S_Data SHALL be loaded with lane=0, the state SHALL stay SEND, and output SHALL be continuous.
REQ-021 In all other cases S_Ready SHALL be 0.
REQ-022 M_Last SHALL be 1 only in SEND when lane=RATIO-1 and beat_cnt=Frame_Len-1.
REQ-023 In DONE, Done SHALL be 1 for exactly one cycle, and the state SHALL then return to IDLE.
REQ-024 Latency from S_Valid&&S_Ready to the first M_Valid SHALL be 1 cycle.
REQ-025 beat_cnt SHALL be LEN_WIDTH bits wide and SHALL NOT wrap for Frame_Len up to 2^LEN_WIDTH-1.

Reset
REQ-026 While rst=0, the state SHALL be IDLE and S_Ready, M_Valid, M_Last, Busy, Done, beat_cnt, lane and the holding register SHALL be 0, asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no further M_Valid; the first frame after reset release SHALL start only on a new Start.

Structure
REQ-028 A shared package SHALL hold the state enum, the IN_WIDTH/OUT_WIDTH/LEN_WIDTH defaults and RATIO.
REQ-029 The block SHALL have no sub-module; the lane mux and the FSM SHALL reside in out_width_converter.

Verification
REQ-030 Frame_Len=2, S_Data beat0=0x...0004_0003_0002_0001 (64-bit lanes), M_Ready=1 -> M_Data 1,2,3,4 then beat1 lanes, 8 contiguous M_Valid cycles, M_Last on the 8th only, Done 1 cycle later.
REQ-031 Frame_Len=0 with Start -> Busy high for 1 cycle, Done pulse, no S_Ready, no M_Valid.
REQ-032 Frame_Len=3, M_Ready toggling 1010 -> M_Data held stable while stalled, 12 transfers, M_Last on the 12th.
REQ-033 Frame_Len=4, S_Valid delayed 5 cycles per beat -> M_Valid low during the gaps, correct lane order, beat_cnt=4 at Done.
REQ-034 rst pulsed low at the 3rd lane of beat 1 -> all outputs 0 immediately; a new Start with Frame_Len=1 produces exactly 4 transfers.
REQ-035 Start reasserted during SEND -> ignored; frame length unchanged.
